parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Sequences the single shared entry/exit gate of the parking lot. It arbitrates between one entry requester and per-slot exit requesters, allocates the lowest-numbered free slot to each arriving car, and tracks slot occupancy. It emits the one-cycle one-hot `car_entry`/`car_exit` pulses that drive the per-slot parking timer. It sits between the gate sensors/buttons and the timer/display datapath.

## Interface
- `NUM_SLOTS`, 4: number of parking slots; width of the slot vectors.
- `GATE_CYCLES`, 24'd5_000_000: number of cycles `gate_open` stays high per admitted car; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `entry_req`  in  1  level request from the entry sensor; held until `entry_ack`.
- `exit_req`  in  NUM_SLOTS  per-slot level exit requests; each bit is held until its `car_exit` bit pulses.
- `entry_ack`  out  1  one-cycle pulse: entry granted.
- `car_entry`  out  NUM_SLOTS  one-hot one-cycle pulse: slot just allocated.
- `car_exit`  out  NUM_SLOTS  one-hot one-cycle pulse: slot just released.
- `gate_open`  out  1  gate actuator drive.
- `occupied`  out  NUM_SLOTS  current slot occupancy map.
- `lot_full`  out  1  high when all `occupied` bits are 1.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, GATE.
- IDLE: requests are sampled only in this state.
- Valid exit candidates: `exit_req & occupied`. Exit requests for unoccupied slots are ignored and never acknowledged.
- Valid entry candidate: `entry_req & ~lot_full`.
- Exit selection: when several exit candidates are valid, the lowest index wins. The others stay pending.
- Entry grant:
  - Allocated slot = lowest index with `occupied` = 0.
  - Set that `occupied` bit.
  - Pulse `entry_ack` and the matching `car_entry` bit.
  - Go to GATE.
- Exit grant:
  - Clear the selected `occupied` bit.
  - Pulse the matching `car_exit` bit.
  - Go to GATE.
- Entry vs exit arbitration when both are valid: see Configuration.
- Lot full: an entry request stays pending with no acknowledge. `lot_full` = 1. Exits are still served.
- GATE:
  - `gate_open` = 1.
  - A down-counter loaded with GATE_CYCLES-1 decrements each cycle.
  - At 0, return to IDLE.
- A requester that drops its request before the grant withdraws it, with no side effect.
- Reset values: every output = 0; `occupied` = 0; state = IDLE; counter = 0; arbitration pointer = entry-first.
- Reset asserted mid-GATE: the gate closes immediately and occupancy is lost.

## Timing
- Request visible in IDLE during cycle N → `entry_ack`/`car_entry` or `car_exit`, and the updated `occupied`, are registered high during cycle N+1.
- `gate_open` is high for exactly GATE_CYCLES cycles, N+1 … N+GATE_CYCLES.
- The FSM is back in IDLE in cycle N+GATE_CYCLES+1, so the next grant appears no earlier than N+GATE_CYCLES+2.
- Pulses (`entry_ack`, `car_entry`, `car_exit`) are exactly 1 cycle wide. Each is asserted at most once per grant.
- All outputs are registered. `lot_full` is derived from the registered `occupied` and reflects it in the same cycle.
- Throughput is at most one car per GATE_CYCLES+1 cycles.

## Configuration
- `PARKING_ROUND_ROBIN_EN` defined:
  - When entry and exit are both valid in IDLE, the winner alternates.
  - A 1-bit pointer flips after every contested grant.
  - The first contest after reset goes to entry.
- `PARKING_ROUND_ROBIN_EN` undefined:
  - Exit always wins contested cycles (fixed priority).
  - No pointer register is present.

## Structure
- Shared package `parking_pkg`:
  - default NUM_SLOTS and GATE_CYCLES constants
  - FSM state encoding (IDLE, GATE)
  - slot index width constant `$clog2(NUM_SLOTS)`
- One sub-module, `slot_allocator`: a parameterised lowest-index priority encoder returning a one-hot vector plus a valid flag. It is instantiated twice, on `~occupied` for entry and on `exit_req & occupied` for exit.

## Test plan
- Reset, then `entry_req` held, GATE_CYCLES=4 → `entry_ack` and `car_entry`=4'b0001 in cycle N+1, `gate_open` high for 4 cycles, `occupied`=4'b0001.
- Four successive entries, then a fifth `entry_req` → slots 0,1,2,3 allocated in order; `lot_full`=1; the fifth request is never acknowledged.
- Full lot, `exit_req`=4'b0110 → `car_exit`=4'b0010 first, then 4'b0100 after the gate cycle; `occupied`=4'b1001; `lot_full` drops after the first exit.
- `exit_req`=4'b1000 with `occupied`=4'b0001 → no `car_exit`, FSM stays IDLE, `busy`=0.
- `entry_req` and a valid exit raised in the same cycle, twice in succession:
  - with `PARKING_ROUND_ROBIN_EN`: entry, then exit
  - without it: exit, then entry
- Reset asserted during cycle 2 of GATE → `gate_open`, `occupied` and `busy` are 0 in the next sampled cycle; a new entry then allocates slot 0.

Source files
------------

// File: rtl/parking_pkg.sv
// ----------------------------------------------------------------------------
// parking_pkg
// Shared constants and types for the parking gate controller slice.
//   DEFAULT_NUM_SLOTS   : default number of parking slots
//   DEFAULT_GATE_CYCLES : default number of cycles the gate stays open per car
//   SLOT_IDX_W          : width of a binary slot index
//   GATE_CNT_W          : width of the gate down-counter
//   gate_state_t        : controller FSM encoding (IDLE, GATE)
//   onehot_to_index     : converts a one-hot slot vector into a binary index
// ----------------------------------------------------------------------------
package parking_pkg;

    localparam int               DEFAULT_NUM_SLOTS   = 4;
    localparam int               GATE_CNT_W          = 24;
    localparam logic [GATE_CNT_W-1:0] DEFAULT_GATE_CYCLES = 24'd5_000_000;
    localparam int               SLOT_IDX_W          = $clog2(DEFAULT_NUM_SLOTS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } gate_state_t;

    // Binary index of the set bit of a one-hot slot vector (0 when empty).
    function automatic logic [SLOT_IDX_W-1:0] onehot_to_index(
        input logic [DEFAULT_NUM_SLOTS-1:0] onehot
    );
        logic [SLOT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEFAULT_NUM_SLOTS; i++) begin
            if (onehot[i]) begin
                idx = i[SLOT_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// ----------------------------------------------------------------------------
// parking_gate_controller_if
// Bundles the sensor requests and the controller status/pulse outputs.
//   master : gate sensors / buttons side (drives entry_req, exit_req)
//   slave  : parking_gate_controller side (drives acks, pulses, gate, status)
// Signals:
//   entry_req  level entry request, held until entry_ack
//   exit_req   per-slot level exit requests, held until matching car_exit
//   entry_ack  one-cycle entry grant pulse
//   car_entry  one-hot one-cycle pulse, slot just allocated
//   car_exit   one-hot one-cycle pulse, slot just released
//   gate_open  gate actuator drive
//   occupied   slot occupancy map
//   lot_full   all slots occupied
//   busy       controller not idle
// ----------------------------------------------------------------------------
interface parking_gate_controller_if #(
    parameter int NUM_SLOTS = parking_pkg::DEFAULT_NUM_SLOTS
);
    logic                 entry_req;
    logic [NUM_SLOTS-1:0] exit_req;
    logic                 entry_ack;
    logic [NUM_SLOTS-1:0] car_entry;
    logic [NUM_SLOTS-1:0] car_exit;
    logic                 gate_open;
    logic [NUM_SLOTS-1:0] occupied;
    logic                 lot_full;
    logic                 busy;

    modport master (
        output entry_req,
        output exit_req,
        input  entry_ack,
        input  car_entry,
        input  car_exit,
        input  gate_open,
        input  occupied,
        input  lot_full,
        input  busy
    );

    modport slave (
        input  entry_req,
        input  exit_req,
        output entry_ack,
        output car_entry,
        output car_exit,
        output gate_open,
        output occupied,
        output lot_full,
        output busy
    );
endinterface

// File: rtl/parking_gate_controller_slot_allocator.sv
// ----------------------------------------------------------------------------
// slot_allocator
// Lowest-index-first priority encoder.
//   req   in  WIDTH  candidate vector
//   grant out WIDTH  one-hot, lowest set bit of req (zero when req is zero)
//   valid out 1      at least one candidate present
// ----------------------------------------------------------------------------
module slot_allocator #(
    parameter int WIDTH = parking_pkg::DEFAULT_NUM_SLOTS
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             valid
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/parking_gate_controller.sv
// ----------------------------------------------------------------------------
// parking_gate_controller
// Sequences the shared entry/exit gate: arbitrates one entry requester
// against per-slot exit requesters, allocates the lowest free slot to each
// arriving car, tracks occupancy and holds the gate open for GATE_CYCLES
// cycles after every grant.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high, clears all state
//   bus    parking_gate_controller_if.slave (requests in, pulses/status out)
// Parameters:
//   NUM_SLOTS    number of slots (must match the interface)
//   GATE_CYCLES  cycles gate_open stays high per grant, >= 1
// Build option:
//   PARKING_ROUND_ROBIN_EN  contested entry/exit cycles alternate winner,
//                           entry first after reset; otherwise exit always
//                           wins a contested cycle.
// ----------------------------------------------------------------------------
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int                    NUM_SLOTS   = DEFAULT_NUM_SLOTS,
    parameter logic [GATE_CNT_W-1:0] GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    parking_gate_controller_if.slave    bus
);

    gate_state_t             state_reg, state_next;
    logic [GATE_CNT_W-1:0]   cnt_reg, cnt_next;

    logic [NUM_SLOTS-1:0]    occupied_reg, occupied_next;
    logic [NUM_SLOTS-1:0]    car_entry_reg, car_entry_next;
    logic [NUM_SLOTS-1:0]    car_exit_reg, car_exit_next;
    logic                    entry_ack_reg, entry_ack_next;
    logic                    gate_open_reg, gate_open_next;
    logic                    busy_reg, busy_next;

`ifdef PARKING_ROUND_ROBIN_EN
    // 1 means exit gets the next contested cycle.
    logic                    rr_exit_reg, rr_exit_next;
`endif

    logic [NUM_SLOTS-1:0]    free_onehot;
    logic                    free_valid;
    logic [NUM_SLOTS-1:0]    exit_cand;
    logic [NUM_SLOTS-1:0]    exit_onehot;
    logic                    exit_valid;
    logic                    entry_valid;
    logic                    contested;
    logic                    grant_entry;
    logic                    grant_exit;

    // Entry slot: lowest free slot. Exit: lowest occupied slot requesting.
    slot_allocator #(.WIDTH(NUM_SLOTS)) u_entry_alloc (
        .req   (~occupied_reg),
        .grant (free_onehot),
        .valid (free_valid)
    );

    assign exit_cand = bus.exit_req & occupied_reg;

    slot_allocator #(.WIDTH(NUM_SLOTS)) u_exit_alloc (
        .req   (exit_cand),
        .grant (exit_onehot),
        .valid (exit_valid)
    );

    // A free slot exists exactly when the lot is not full.
    assign entry_valid = bus.entry_req & free_valid;
    assign contested   = entry_valid & exit_valid;

    // ------------------------------------------------------------------
    // State register (all state and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            occupied_reg  <= '0;
            car_entry_reg <= '0;
            car_exit_reg  <= '0;
            entry_ack_reg <= 1'b0;
            gate_open_reg <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef PARKING_ROUND_ROBIN_EN
            rr_exit_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            occupied_reg  <= occupied_next;
            car_entry_reg <= car_entry_next;
            car_exit_reg  <= car_exit_next;
            entry_ack_reg <= entry_ack_next;
            gate_open_reg <= gate_open_next;
            busy_reg      <= busy_next;
`ifdef PARKING_ROUND_ROBIN_EN
            rr_exit_reg   <= rr_exit_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: arbitration and gate timing
    // ------------------------------------------------------------------
    always_comb begin
        logic pick_exit;
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        grant_entry = 1'b0;
        grant_exit  = 1'b0;
        pick_exit   = 1'b0;
`ifdef PARKING_ROUND_ROBIN_EN
        rr_exit_next = rr_exit_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (contested) begin
`ifdef PARKING_ROUND_ROBIN_EN
                    pick_exit    = rr_exit_reg;
                    rr_exit_next = ~rr_exit_reg;
`else
                    pick_exit    = 1'b1;
`endif
                    grant_exit  = pick_exit;
                    grant_entry = ~pick_exit;
                end else begin
                    grant_exit  = exit_valid;
                    grant_entry = entry_valid;
                end

                if (grant_entry || grant_exit) begin
                    state_next = ST_GATE;
                    cnt_next   = GATE_CYCLES - 1'b1;
                end
            end

            ST_GATE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        entry_ack_next = grant_entry;
        car_entry_next = grant_entry ? free_onehot : '0;
        car_exit_next  = grant_exit  ? exit_onehot : '0;
        occupied_next  = (occupied_reg | car_entry_next) & ~car_exit_next;
        // Gate and busy follow the state being entered so they line up
        // with the registered state in the same cycle.
        gate_open_next = (state_next == ST_GATE);
        busy_next      = (state_next != ST_IDLE);
    end

    assign bus.entry_ack = entry_ack_reg;
    assign bus.car_entry = car_entry_reg;
    assign bus.car_exit  = car_exit_reg;
    assign bus.gate_open = gate_open_reg;
    assign bus.occupied  = occupied_reg;
    assign bus.lot_full  = &occupied_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;
    import parking_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    parking_gate_controller_if #(.NUM_SLOTS(4)) bus ();

    parking_gate_controller #(
        .NUM_SLOTS   (4),
        .GATE_CYCLES (24'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [15:0] all_out;
        reset = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 4'b0000;
        repeat (2) @(negedge clk);
        all_out = {bus.entry_ack, bus.car_entry, bus.car_exit, bus.gate_open,
                   bus.occupied, bus.lot_full, bus.busy};
        n_checks++;
        if (all_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000", all_out);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.occupied, bus.busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 00000", {bus.occupied, bus.busy});
        end
        $display("reset done");
    endtask

    task automatic test_single_entry();
        bus.entry_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.entry_ack !== 1'b1) begin
            n_fail++; $display("FAIL single_entry_ack: got %b expected 1", bus.entry_ack);
        end
        n_checks++;
        if (bus.car_entry !== 4'b0001) begin
            n_fail++; $display("FAIL single_car_entry: got %b expected 0001", bus.car_entry);
        end
        n_checks++;
        if (bus.occupied !== 4'b0001) begin
            n_fail++; $display("FAIL single_occupied: got %b expected 0001", bus.occupied);
        end
        n_checks++;
        if ({bus.gate_open, bus.busy} !== 2'b11) begin
            n_fail++; $display("FAIL single_gate_busy: got %b expected 11", {bus.gate_open, bus.busy});
        end
        $display("entry grant car_entry=%b slot=%0d", bus.car_entry, onehot_to_index(bus.car_entry));
        bus.entry_req = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.gate_open, bus.entry_ack, bus.car_entry} !== 6'b100000) begin
                n_fail++;
                $display("FAIL single_gate_cycle%0d: got %b expected 100000", i,
                         {bus.gate_open, bus.entry_ack, bus.car_entry});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus.gate_open, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_gate_closed: got %b expected 00", {bus.gate_open, bus.busy});
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_slot;
        for (int k = 1; k <= 3; k++) begin
            exp_slot = 4'b0001 << k;
            bus.entry_req = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.car_entry !== exp_slot) begin
                n_fail++; $display("FAIL fill_car_entry%0d: got %b expected %b", k, bus.car_entry, exp_slot);
            end
            $display("entry grant car_entry=%b occupied=%b", bus.car_entry, bus.occupied);
            bus.entry_req = 1'b0;
            repeat (4) @(negedge clk);
        end
        n_checks++;
        if ({bus.lot_full, bus.occupied} !== 5'b11111) begin
            n_fail++; $display("FAIL fill_lot_full: got %b expected 11111", {bus.lot_full, bus.occupied});
        end
        bus.entry_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.entry_ack, bus.busy, bus.car_entry} !== 6'b000000) begin
                n_fail++;
                $display("FAIL fill_fifth_ignored: got %b expected 000000",
                         {bus.entry_ack, bus.busy, bus.car_entry});
            end
        end
        bus.entry_req = 1'b0;
        $display("fifth entry held pending while full");
    endtask

    task automatic test_exit_full();
        bus.exit_req = 4'b0110;
        @(negedge clk);
        n_checks++;
        if (bus.car_exit !== 4'b0010) begin
            n_fail++; $display("FAIL exit1_car_exit: got %b expected 0010", bus.car_exit);
        end
        n_checks++;
        if ({bus.occupied, bus.lot_full} !== 5'b11010) begin
            n_fail++; $display("FAIL exit1_occ_full: got %b expected 11010", {bus.occupied, bus.lot_full});
        end
        $display("exit grant car_exit=%b occupied=%b", bus.car_exit, bus.occupied);
        bus.exit_req = 4'b0100;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus.car_exit, bus.busy} !== 5'b00000) begin
            n_fail++; $display("FAIL exit_idle_gap: got %b expected 00000", {bus.car_exit, bus.busy});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.car_exit, bus.occupied} !== 8'b0100_1001) begin
            n_fail++; $display("FAIL exit2: got %b expected 01001001", {bus.car_exit, bus.occupied});
        end
        $display("exit grant car_exit=%b occupied=%b", bus.car_exit, bus.occupied);
        bus.exit_req = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ignored_exit();
        bus.exit_req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({bus.car_exit, bus.occupied} !== 8'b1000_0001) begin
            n_fail++; $display("FAIL exit3: got %b expected 10000001", {bus.car_exit, bus.occupied});
        end
        $display("exit grant car_exit=%b occupied=%b", bus.car_exit, bus.occupied);
        bus.exit_req = 4'b0000;
        repeat (4) @(negedge clk);
        bus.exit_req = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.car_exit, bus.busy, bus.gate_open} !== 6'b000000) begin
                n_fail++;
                $display("FAIL ignored_exit: got %b expected 000000", {bus.car_exit, bus.busy, bus.gate_open});
            end
        end
        n_checks++;
        if (bus.occupied !== 4'b0001) begin
            n_fail++; $display("FAIL ignored_exit_occ: got %b expected 0001", bus.occupied);
        end
        bus.exit_req = 4'b0000;
        $display("exit on empty slot ignored");
    endtask

    task automatic test_contest();
        logic [3:0] e1_entry, e1_exit, e1_occ, e2_entry, e2_exit, e2_occ;
        logic [3:0] c2_occ, c2_entry_occ, c2_entry;
`ifdef PARKING_ROUND_ROBIN_EN
        e1_entry = 4'b0100; e1_exit = 4'b0000; e1_occ = 4'b0111;
        e2_entry = 4'b0000; e2_exit = 4'b0001; e2_occ = 4'b0110;
        c2_occ = 4'b0100; c2_entry = 4'b0001; c2_entry_occ = 4'b0101;
`else
        e1_entry = 4'b0000; e1_exit = 4'b0001; e1_occ = 4'b0010;
        e2_entry = 4'b0001; e2_exit = 4'b0000; e2_occ = 4'b0011;
        c2_occ = 4'b0001; c2_entry = 4'b0010; c2_entry_occ = 4'b0011;
`endif
        bus.entry_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.car_entry !== 4'b0010) begin
            n_fail++; $display("FAIL contest_setup: got %b expected 0010", bus.car_entry);
        end
        bus.entry_req = 1'b0;
        repeat (4) @(negedge clk);

        bus.entry_req = 1'b1;
        bus.exit_req  = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({bus.car_entry, bus.car_exit, bus.occupied} !== {e1_entry, e1_exit, e1_occ}) begin
            n_fail++; $display("FAIL contest1_first: got %b expected %b",
                               {bus.car_entry, bus.car_exit, bus.occupied}, {e1_entry, e1_exit, e1_occ});
        end
        $display("contest1 grant car_entry=%b car_exit=%b", bus.car_entry, bus.car_exit);
        if (e1_exit != 4'b0000) bus.exit_req = 4'b0000;
        else bus.entry_req = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.car_entry, bus.car_exit, bus.occupied} !== {e2_entry, e2_exit, e2_occ}) begin
            n_fail++; $display("FAIL contest1_second: got %b expected %b",
                               {bus.car_entry, bus.car_exit, bus.occupied}, {e2_entry, e2_exit, e2_occ});
        end
        $display("contest1 follow-up car_entry=%b car_exit=%b", bus.car_entry, bus.car_exit);
        bus.entry_req = 1'b0;
        bus.exit_req  = 4'b0000;
        repeat (4) @(negedge clk);

        bus.entry_req = 1'b1;
        bus.exit_req  = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({bus.car_entry, bus.car_exit, bus.occupied} !== {4'b0000, 4'b0010, c2_occ}) begin
            n_fail++; $display("FAIL contest2_first: got %b expected %b",
                               {bus.car_entry, bus.car_exit, bus.occupied}, {4'b0000, 4'b0010, c2_occ});
        end
        $display("contest2 grant car_exit=%b", bus.car_exit);
        bus.exit_req = 4'b0000;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.entry_ack, bus.car_entry, bus.occupied} !== {1'b1, c2_entry, c2_entry_occ}) begin
            n_fail++; $display("FAIL contest2_second: got %b expected %b",
                               {bus.entry_ack, bus.car_entry, bus.occupied}, {1'b1, c2_entry, c2_entry_occ});
        end
        $display("contest2 follow-up car_entry=%b", bus.car_entry);
        bus.entry_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_gate();
        bus.entry_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gate_open !== 1'b1) begin
            n_fail++; $display("FAIL midreset_gate_open: got %b expected 1", bus.gate_open);
        end
        bus.entry_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.gate_open, bus.occupied, bus.busy} !== 6'b000000) begin
            n_fail++; $display("FAIL midreset_cleared: got %b expected 000000",
                               {bus.gate_open, bus.occupied, bus.busy});
        end
        reset = 1'b0;
        @(negedge clk);
        bus.entry_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.car_entry, bus.occupied} !== 8'b0001_0001) begin
            n_fail++; $display("FAIL midreset_new_entry: got %b expected 00010001",
                               {bus.car_entry, bus.occupied});
        end
        $display("post-reset entry car_entry=%b", bus.car_entry);
        bus.entry_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 4'b0000;
        test_reset();
        test_single_entry();
        test_fill();
        test_exit_full();
        test_ignored_exit();
        test_contest();
        test_reset_mid_gate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
